// File: rtl/store_pkg.sv
// Shared types and helpers for the result store engine.
// Optional feature macro used by this block: RESULT_STORE_RELU_EN.
package store_pkg;

  localparam int LANE_W         = 32;
  localparam int MAX_MASK_BYTES = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DATA = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } store_state_e;

  // Byte enables for a column group holding rem valid lanes (rem==0 means all lanes valid).
  function automatic logic [MAX_MASK_BYTES-1:0] tail_mask(input logic [7:0] rem);
    logic [MAX_MASK_BYTES-1:0] m;
    m = {MAX_MASK_BYTES{1'b0}};
    for (int i = 0; i < MAX_MASK_BYTES; i++) begin
      m[i] = ((rem == 8'd0) || (i < int'(rem) * 4)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/store_addr_gen.sv
// Row/column walker for the store engine: tracks the current column group,
// the running row base address and flags the end of a row and of the tile.
module store_addr_gen
  import store_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DWIDTH  = 128,
  parameter int NUM_BUF = 4,
  parameter int RW      = 5,
  parameter int CW      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [RW-1:0]     msize,
  input  logic [RW-1:0]     nb,
  output logic [CW-1:0]     col,
  output logic [ADDR_W-1:0] word_addr,
  output logic              last_col,
  output logic              last_row
);

  logic [RW-1:0]     row_r;
  logic [CW-1:0]     col_r;
  logic [ADDR_W-1:0] row_addr_r;

  // Counter and row-address update: restart on init, step on each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r      <= {RW{1'b0}};
      col_r      <= {CW{1'b0}};
      row_addr_r <= {ADDR_W{1'b0}};
    end else if (init) begin
      row_r      <= {RW{1'b0}};
      col_r      <= {CW{1'b0}};
      row_addr_r <= base_addr;
    end else if (advance) begin
      if (!last_col) begin
        col_r <= col_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (!last_row) begin
        row_r      <= row_r + {{(RW-1){1'b0}}, 1'b1};
        col_r      <= {CW{1'b0}};
        row_addr_r <= row_addr_r + row_stride;
      end else begin
        row_r <= row_r;
      end
    end else begin
      row_r <= row_r;
    end
  end

  assign col       = col_r;
  assign word_addr = row_addr_r + ADDR_W'(col_r) * ADDR_W'(DWIDTH / 8);
  assign last_col  = (32'(col_r) == (32'(nb) - 32'd1));
  assign last_row  = (32'(row_r) == (32'(msize) - 32'd1));

endmodule

// File: rtl/result_store_engine.sv
// Result store engine: drains NUM_BUF accumulator buffers row by row to the
// memory interface with strided addressing and partial-group byte masking.
// Optional macro RESULT_STORE_RELU_EN adds a latched relu_en input that
// clamps negative 32-bit lanes to zero on the way out.
module result_store_engine
  import store_pkg::*;
#(
  parameter int DWIDTH  = 128,
  parameter int NUM_BUF = 4,
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef RESULT_STORE_RELU_EN
  input  logic                        relu_en,
`endif
  input  logic [ADDR_W-1:0]           tile_C_addr,
  input  logic [ADDR_W-1:0]           row_stride,
  input  logic [$clog2(MAX_DIM):0]    msize,
  input  logic [$clog2(MAX_DIM):0]    nsize,
  input  logic [NUM_BUF-1:0]          buf_empty,
  input  logic [NUM_BUF*DWIDTH-1:0]   buf_data,
  output logic [NUM_BUF-1:0]          buf_rd_en,
  output logic                        if_en,
  output logic                        if_rdwr,
  output logic [ADDR_W-1:0]           if_addr,
  output logic [DWIDTH-1:0]           if_wr_data,
  output logic [DWIDTH/8-1:0]         if_wr_mask,
  input  logic                        if_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int LANES = DWIDTH / LANE_W;
  localparam int BYTES = DWIDTH / 8;
  localparam int RW    = $clog2(MAX_DIM) + 1;
  localparam int CW    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

  store_state_e      state_r, next_s;
  logic [ADDR_W-1:0] base_r, stride_r;
  logic [RW-1:0]     msize_r, nsize_r, nb_s;
  logic [7:0]        rem_s;
  logic              init_s, adv_s, wr_s;
  logic [NUM_BUF-1:0] rd_s;
  logic [CW-1:0]     col_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic              last_col_s, last_row_s;
  logic [DWIDTH-1:0] data_s;
  logic [BYTES-1:0]  mask_s;
  logic [DWIDTH-1:0] buf_word_s [NUM_BUF];
`ifdef RESULT_STORE_RELU_EN
  logic              relu_r;
`endif

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_word
    assign buf_word_s[b] = buf_data[b*DWIDTH +: DWIDTH];
  end

  assign nb_s  = RW'((32'(nsize_r) + LANES - 1) / LANES);
  assign rem_s = 8'(32'(nsize_r) % LANES);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Capture the tile descriptor on an accepted grant, clamping sizes to MAX_DIM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r   <= {ADDR_W{1'b0}};
      stride_r <= {ADDR_W{1'b0}};
      msize_r  <= {RW{1'b0}};
      nsize_r  <= {RW{1'b0}};
`ifdef RESULT_STORE_RELU_EN
      relu_r   <= 1'b0;
`endif
    end else if (state_r == IDLE && start) begin
      base_r   <= tile_C_addr;
      stride_r <= row_stride;
      msize_r  <= (32'(msize) > MAX_DIM) ? RW'(MAX_DIM) : msize;
      nsize_r  <= (32'(nsize) > MAX_DIM) ? RW'(MAX_DIM) : nsize;
`ifdef RESULT_STORE_RELU_EN
      relu_r   <= relu_en;
`endif
    end else begin
      base_r <= base_r;
    end
  end

  // Next-state logic plus handshake: pop the current buffer in the accept cycle.
  always_comb begin
    next_s = state_r;
    init_s = 1'b0;
    adv_s  = 1'b0;
    wr_s   = 1'b0;
    rd_s   = {NUM_BUF{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) next_s = LOAD;
        else       next_s = IDLE;
      end
      LOAD: begin
        init_s = 1'b1;
        if (msize_r == {RW{1'b0}} || nsize_r == {RW{1'b0}}) next_s = DONE;
        else                                                 next_s = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (!buf_empty[col_s]) next_s = WRITE;
        else                   next_s = WAIT_DATA;
      end
      WRITE: begin
        wr_s = 1'b1;
        if (if_ready) begin
          adv_s       = 1'b1;
          rd_s[col_s] = 1'b1;
          if (last_col_s && last_row_s) next_s = DONE;
          else                          next_s = WAIT_DATA;
        end else begin
          next_s = WRITE;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Data path: select the current buffer head and optionally clamp negative lanes.
  always_comb begin
    data_s = buf_word_s[col_s];
`ifdef RESULT_STORE_RELU_EN
    for (int l = 0; l < LANES; l++) begin
      data_s[l*LANE_W +: LANE_W] = (relu_r && data_s[l*LANE_W + LANE_W - 1]) ?
                                   {LANE_W{1'b0}} : data_s[l*LANE_W +: LANE_W];
    end
`endif
    if (last_col_s) mask_s = BYTES'(tail_mask(rem_s));
    else            mask_s = {BYTES{1'b1}};
  end

  store_addr_gen #(
    .ADDR_W (ADDR_W),
    .DWIDTH (DWIDTH),
    .NUM_BUF(NUM_BUF),
    .RW     (RW),
    .CW     (CW)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .init      (init_s),
    .advance   (adv_s),
    .base_addr (base_r),
    .row_stride(stride_r),
    .msize     (msize_r),
    .nb        (nb_s),
    .col       (col_s),
    .word_addr (word_addr_s),
    .last_col  (last_col_s),
    .last_row  (last_row_s)
  );

  assign buf_rd_en  = rd_s;
  assign if_en      = wr_s;
  assign if_rdwr    = wr_s;
  assign if_addr    = wr_s ? word_addr_s : {ADDR_W{1'b0}};
  assign if_wr_data = wr_s ? data_s : {DWIDTH{1'b0}};
  assign if_wr_mask = wr_s ? mask_s : {BYTES{1'b0}};
  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);

endmodule

// File: tb/tb_result_store_engine.sv
// Directed self-checking bench for result_store_engine (default parameters).
module tb_result_store_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  tile_C_addr = 32'h0;
  logic [31:0]  row_stride = 32'h0;
  logic [4:0]   msize = 5'd0;
  logic [4:0]   nsize = 5'd0;
  logic [3:0]   buf_empty;
  logic [511:0] buf_data;
  logic [3:0]   buf_rd_en;
  logic         if_en, if_rdwr, if_ready, busy, done;
  logic [31:0]  if_addr;
  logic [127:0] if_wr_data;
  logic [15:0]  if_wr_mask;
`ifdef RESULT_STORE_RELU_EN
  logic         relu_en = 1'b0;
`endif

  logic [3:0]   empty_force = 4'b0000;
  logic         ovr_en = 1'b0;
  logic [127:0] ovr_word = 128'h0;
  int           pop_cnt [4] = '{0, 0, 0, 0};
  int           k0 [4];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           done_cnt = 0;
  int           rd_bad = 0;
  int           rdwr_bad = 0;
  int           cyc = 0;

  logic [31:0]  wr_addr [$];
  logic [127:0] wr_data [$];
  logic [15:0]  wr_mask [$];
  logic [3:0]   wr_rd [$];
  int           wr_cyc [$];

  always #5 clk = ~clk;

  result_store_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef RESULT_STORE_RELU_EN
    .relu_en    (relu_en),
`endif
    .tile_C_addr(tile_C_addr),
    .row_stride (row_stride),
    .msize      (msize),
    .nsize      (nsize),
    .buf_empty  (buf_empty),
    .buf_data   (buf_data),
    .buf_rd_en  (buf_rd_en),
    .if_en      (if_en),
    .if_rdwr    (if_rdwr),
    .if_addr    (if_addr),
    .if_wr_data (if_wr_data),
    .if_wr_mask (if_wr_mask),
    .if_ready   (if_ready),
    .busy       (busy),
    .done       (done)
  );

  // Buffer word k of buffer b: every lane tagged with buffer, pop index and lane number.
  function automatic logic [127:0] word_of(input int b, input int k);
    logic [127:0] w;
    for (int l = 0; l < 4; l++) w[l*32 +: 32] = {8'(b + 1), 8'(k), 8'h00, 8'(l)};
    return w;
  endfunction

  // FWFT buffer model heads.
  always_comb begin
    for (int b = 0; b < 4; b++) buf_data[b*128 +: 128] = word_of(b, pop_cnt[b]);
    if (ovr_en) buf_data[127:0] = ovr_word;
    buf_empty = empty_force;
  end

  // Buffer model pops.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int b = 0; b < 4; b++) if (buf_rd_en[b]) pop_cnt[b] <= pop_cnt[b] + 1;
  end

  // Interface monitor: log accepted writes and count anomalies.
  always @(negedge clk) begin
    if (if_en && if_ready) begin
      wr_addr.push_back(if_addr);
      wr_data.push_back(if_wr_data);
      wr_mask.push_back(if_wr_mask);
      wr_rd.push_back(buf_rd_en);
      wr_cyc.push_back(cyc);
    end
    if (buf_rd_en != 4'b0000 && !(if_en && if_ready)) rd_bad <= rd_bad + 1;
    if (if_en && !if_rdwr) rdwr_bad <= rdwr_bad + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep();
    wr_addr.delete(); wr_data.delete(); wr_mask.delete(); wr_rd.delete(); wr_cyc.delete();
    for (int b = 0; b < 4; b++) k0[b] = pop_cnt[b];
  endtask

  task automatic set_desc(input logic [31:0] base, input logic [31:0] stride,
                          input logic [4:0] m, input logic [4:0] n);
    tile_C_addr = base; row_stride = stride; msize = m; nsize = n;
  endtask

  // Pulse start; return posedges until the selected event (0: if_en, 1: done) is seen.
  task automatic start_measure(input int sel, output int n);
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      n++;
      #1 start = 1'b0;
      @(negedge clk);
      if ((sel == 0 && if_en) || (sel == 1 && done)) break;
    end
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 128'(seen), 128'd1);
    tick();
  endtask

  task automatic verify_writes(input string tag, input logic [31:0] base, input logic [31:0] stride,
                               input int rows, input int nb, input logic [15:0] last_mask);
    check({tag, "_count"}, 128'(wr_addr.size()), 128'(rows * nb));
    if (wr_addr.size() == rows * nb) begin
      for (int j = 0; j < rows * nb; j++) begin
        int r = j / nb;
        int c = j % nb;
        logic [31:0] ea = base + 32'(r) * stride + 32'(c) * 32'h10;
        check($sformatf("%s_addr%0d", tag, j), 128'(wr_addr[j]), 128'(ea));
        check($sformatf("%s_data%0d", tag, j), wr_data[j], word_of(c, k0[c] + r));
        check($sformatf("%s_mask%0d", tag, j), 128'(wr_mask[j]),
              128'((c == nb - 1) ? last_mask : 16'hFFFF));
        check($sformatf("%s_pop%0d", tag, j), 128'(wr_rd[j]), 128'(4'b0001 << c));
      end
    end
  endtask

  initial begin
    int n, dn;
    logic [31:0]  a0;
    logic [127:0] d0;
    logic [15:0]  m0;
    bit           stable, stall_ok;
    logic [3:0]   rd_or;

    if_ready = 1'b1;
    repeat (3) tick();
    // Reset state
    check("reset_outputs", {if_en, if_rdwr, if_addr, if_wr_mask, buf_rd_en, busy, done},
          128'd0);
    check("reset_data", if_wr_data, 128'd0);
    rst = 1'b0;
    tick();

    // Full tile: 4 rows x 16 columns
    prep(); dn = done_cnt;
    set_desc(32'h1000, 32'h40, 5'd4, 5'd16);
    start_measure(0, n);
    check("full_latency", 128'(n), 128'd3);
    check("full_busy", 128'(busy), 128'd1);
    wait_done("full");
    verify_writes("full", 32'h1000, 32'h40, 4, 4, 16'hFFFF);
    if (wr_addr.size() >= 5) begin
      check("full_addr4", 128'(wr_addr[4]), 128'h1040);
      check("full_throughput", 128'(wr_cyc[1] - wr_cyc[0]), 128'd2);
    end
    check("full_done_once", 128'(done_cnt - dn), 128'd1);
    check("full_idle", 128'({busy, done}), 128'd0);

    // Partial columns: nsize=6 -> two groups, second masked to 2 lanes
    prep(); dn = done_cnt;
    set_desc(32'h2000, 32'h100, 5'd2, 5'd6);
    start_measure(0, n);
    wait_done("part");
    verify_writes("part", 32'h2000, 32'h100, 2, 2, 16'h00FF);
    rd_or = 4'b0000;
    foreach (wr_rd[j]) rd_or = rd_or | wr_rd[j];
    check("part_pop_set", 128'(rd_or), 128'(4'b0011));
    check("part_done_once", 128'(done_cnt - dn), 128'd1);

    // Backpressure in the first WRITE
    prep();
    if_ready = 1'b0;
    set_desc(32'h5000, 32'h0, 5'd1, 5'd4);
    start_measure(0, n);
    check("bp_if_en", 128'(if_en), 128'd1);
    a0 = if_addr; d0 = if_wr_data; m0 = if_wr_mask;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if_addr !== a0 || if_wr_data !== d0 || if_wr_mask !== m0 || !if_en ||
          buf_rd_en !== 4'b0000) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'd1);
    if_ready = 1'b1;
    #1;
    check("bp_accept_pop", 128'(buf_rd_en), 128'(4'b0001));
    wait_done("bp");
    verify_writes("bp", 32'h5000, 32'h0, 1, 1, 16'hFFFF);

    // Empty stall on buffer 2 mid-row
    prep();
    empty_force = 4'b0100;
    set_desc(32'h4000, 32'h0, 5'd1, 5'd16);
    start_measure(0, n);
    for (int i = 0; i < 40 && wr_addr.size() < 2; i++) tick();
    check("stall_reached", 128'(wr_addr.size()), 128'd2);
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_en || !busy || done) stall_ok = 1'b0;
    end
    check("stall_hold", 128'(stall_ok), 128'd1);
    tick();
    empty_force = 4'b0000;
    wait_done("stall");
    verify_writes("stall", 32'h4000, 32'h0, 1, 4, 16'hFFFF);

    // Degenerate msize=0
    prep(); dn = done_cnt;
    set_desc(32'h9000, 32'h40, 5'd0, 5'd16);
    start_measure(1, n);
    check("m0_latency", 128'(n), 128'd2);
    tick();
    check("m0_no_writes", 128'(wr_addr.size()), 128'd0);
    check("m0_done_once", 128'(done_cnt - dn), 128'd1);

    // nsize above MAX_DIM clamps to 16
    prep();
    set_desc(32'h8000, 32'h0, 5'd1, 5'd20);
    start_measure(0, n);
    wait_done("clamp");
    verify_writes("clamp", 32'h8000, 32'h0, 1, 4, 16'hFFFF);

    // Address wrap modulo 2^32
    prep();
    set_desc(32'hFFFF_FFF0, 32'h10, 5'd2, 5'd8);
    start_measure(0, n);
    wait_done("wrap");
    verify_writes("wrap", 32'hFFFF_FFF0, 32'h10, 2, 2, 16'hFFFF);
    if (wr_addr.size() == 4) check("wrap_addr1", 128'(wr_addr[1]), 128'h0);

    // Reset during WRITE, then a fresh store
    prep(); dn = done_cnt;
    if_ready = 1'b0;
    set_desc(32'h6000, 32'h40, 5'd2, 5'd16);
    start_measure(0, n);
    rst = 1'b1;
    #1;
    check("rst_outputs", {if_en, if_rdwr, if_addr, if_wr_mask, buf_rd_en, busy, done}, 128'd0);
    check("rst_data", if_wr_data, 128'd0);
    tick(); tick();
    rst = 1'b0;
    if_ready = 1'b1;
    tick();
    check("rst_no_done", 128'(done_cnt - dn), 128'd0);
    check("rst_no_write", 128'(wr_addr.size()), 128'd0);
    prep();
    set_desc(32'h7000, 32'h40, 5'd1, 5'd4);
    start_measure(0, n);
    wait_done("post_rst");
    verify_writes("post_rst", 32'h7000, 32'h40, 1, 1, 16'hFFFF);

`ifdef RESULT_STORE_RELU_EN
    // ReLU clamp of negative lanes
    prep();
    ovr_en = 1'b1;
    ovr_word = {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
    relu_en = 1'b1;
    set_desc(32'hA000, 32'h0, 5'd1, 5'd4);
    start_measure(0, n);
    relu_en = 1'b0;
    wait_done("relu");
    check("relu_count", 128'(wr_data.size()), 128'd1);
    if (wr_data.size() == 1)
      check("relu_data", wr_data[0], {32'd3, 32'h0, 32'd7, 32'h0});
    ovr_en = 1'b0;
`endif

    check("stray_pops", 128'(rd_bad), 128'd0);
    check("rdwr_high", 128'(rdwr_bad), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
